// File: rtl/ldl_fifo_pkg.sv
// Shared constants and helpers for the LDL_sfifo family.
// Prefetch buffer depth and level encoding.
package ldl_fifo_pkg;

  localparam int LDL_BUF_DEPTH = 2;
  localparam int LDL_LVL_W     = $clog2(LDL_BUF_DEPTH + 1);

  typedef logic [LDL_LVL_W-1:0] lvl_t;

  localparam lvl_t LVL_ZERO = lvl_t'(0);
  localparam lvl_t LVL_ONE  = lvl_t'(1);
  localparam lvl_t LVL_FULL = lvl_t'(LDL_BUF_DEPTH);

  // Room for one more word once this cycle's pop and in-flight read settle.
  function automatic logic credit_ok(
    input lvl_t lvl,
    input logic infl,
    input logic pop
  );
    int occ;
    occ = int'(lvl) + int'(infl) - int'(pop);
    return occ < LDL_BUF_DEPTH;
  endfunction

endpackage

// File: rtl/ldl_skid_buf2.sv
// Two-entry FIFO-ordered register buffer.
// Entry 0 is always the head; entry 1 holds the second word.
module ldl_skid_buf2
  import ldl_fifo_pkg::*;
#(
  parameter int DWIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [DWIDTH-1:0]    din_i,
  output logic [DWIDTH-1:0]    head_o,
  output logic [LDL_LVL_W-1:0] level_o
);

  logic [DWIDTH-1:0] e0_q, e0_d;
  logic [DWIDTH-1:0] e1_q, e1_d;
  lvl_t              lvl_q, lvl_d;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    lvl_d = lvl_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (lvl_q == LVL_ZERO) e0_d = din_i;
        else                   e1_d = din_i;
        lvl_d = lvl_q + LVL_ONE;
      end
      2'b01: begin
        if (lvl_q == LVL_FULL) e0_d = e1_q;
        lvl_d = lvl_q - LVL_ONE;
      end
      2'b11: begin
        // Head leaves while a new word joins the tail.
        if (lvl_q == LVL_ONE) begin
          e0_d = din_i;
        end else begin
          e0_d = e1_q;
          e1_d = din_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e0_q  <= '0;
      e1_q  <= '0;
      lvl_q <= LVL_ZERO;
    end else begin
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      lvl_q <= lvl_d;
    end
  end

  assign head_o  = e0_q;
  assign level_o = lvl_q;

endmodule

// File: rtl/ldl_sfifo_rd_stream.sv
// Read-side master for LDL_sfifo: drains the FIFO into a
// valid/ready stream through a 2-entry prefetch buffer.
module ldl_sfifo_rd_stream
  import ldl_fifo_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int AHEAD  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  output logic              fifo_re,
  input  logic [DWIDTH-1:0] fifo_dout,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWIDTH-1:0] m_data,
  output logic [1:0]        level
);

  logic pop;
  logic push;
  logic infl;
  lvl_t lvl;

  assign pop = m_valid & m_ready;

  generate
    if (AHEAD != 0) begin : g_ahead
      assign infl = 1'b0;
      assign push = fifo_re;
    end else begin : g_reg
      // Registered FIFO: data lands one clock after the pop.
      logic infl_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) infl_q <= 1'b0;
        else     infl_q <= fifo_re;
      end
      assign infl = infl_q;
      assign push = infl_q;
    end
  endgenerate

  // m_ready reaches fifo_re combinationally so a pop frees a slot at once.
  assign fifo_re = ~fifo_empty & credit_ok(lvl, infl, pop);

  ldl_skid_buf2 #(
    .DWIDTH (DWIDTH)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_dout),
    .head_o  (m_data),
    .level_o (lvl)
  );

  assign m_valid = (lvl != LVL_ZERO);
  assign level   = lvl;

endmodule

// File: tb/tb_ldl_sfifo_rd_stream.sv
// Bench for ldl_sfifo_rd_stream: AHEAD=1 and AHEAD=0 side by side,
// each fed by its own FIFO model, shared stimulus and scoreboard.
module tb_ldl_sfifo_rd_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       blk = 1'b1;
  logic       fclr = 1'b1;
  logic       we = 1'b0;
  logic [7:0] wd = 8'h00;
  logic       m_ready = 1'b0;

  logic [1:0] re, valid, empty;
  logic [7:0] dout [2];
  logic [7:0] data [2];
  logic [1:0] lvl  [2];

  logic [7:0] fm [2][16];
  int         fcnt [2] = '{0, 0};
  int         frd  [2] = '{0, 0};
  int         fwr  [2] = '{0, 0};
  logic [7:0] fdq = 8'h00;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp0 [$];
  logic [7:0] exp1 [$];
  int         dcnt [2] = '{0, 0};
  logic       pv [2] = '{1'b0, 1'b0};
  logic       pr [2] = '{1'b0, 1'b0};
  logic [7:0] pd [2];
  string      tg [2] = '{"ah1", "ah0"};

  ldl_sfifo_rd_stream #(.DWIDTH(8), .AHEAD(1)) u_a (
    .clk(clk), .rst(rst), .fifo_empty(empty[0]), .fifo_re(re[0]),
    .fifo_dout(dout[0]), .m_valid(valid[0]), .m_ready(m_ready),
    .m_data(data[0]), .level(lvl[0])
  );

  ldl_sfifo_rd_stream #(.DWIDTH(8), .AHEAD(0)) u_r (
    .clk(clk), .rst(rst), .fifo_empty(empty[1]), .fifo_re(re[1]),
    .fifo_dout(dout[1]), .m_valid(valid[1]), .m_ready(m_ready),
    .m_data(data[1]), .level(lvl[1])
  );

  // blk hides preloaded words so a burst can start on a known cycle.
  assign empty[0] = (fcnt[0] == 0) | blk;
  assign empty[1] = (fcnt[1] == 0) | blk;
  assign dout[0]  = fm[0][frd[0]];
  assign dout[1]  = fdq;

  always @(posedge clk or posedge fclr) begin
    if (fclr) begin
      for (int g = 0; g < 2; g++) begin
        fcnt[g] <= 0;
        frd[g]  <= 0;
        fwr[g]  <= 0;
      end
      fdq <= 8'h00;
    end else begin
      for (int g = 0; g < 2; g++) begin
        if (we) begin
          fm[g][fwr[g]] <= wd;
          fwr[g] <= (fwr[g] + 1) % 16;
        end
        if (re[g] && fcnt[g] > 0) begin
          frd[g] <= (frd[g] + 1) % 16;
          if (g == 1) fdq <= fm[1][frd[1]];
        end
        fcnt[g] <= fcnt[g] + (we ? 1 : 0)
                   - ((re[g] && fcnt[g] > 0) ? 1 : 0);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int g = 0; g < 2; g++) begin
      if (rst) begin
        pv[g] = 1'b0;
      end else begin
        check({tg[g], "_uflow"}, {31'd0, re[g] & empty[g]}, 0);
        if (pv[g] && !pr[g]) begin
          check({tg[g], "_vhold"}, {31'd0, valid[g]}, 1);
          check({tg[g], "_dhold"}, {24'd0, data[g]}, {24'd0, pd[g]});
        end
        if (valid[g] && m_ready) begin
          dcnt[g]++;
          if (g == 0) begin
            check({tg[g], "_sbq"}, {31'd0, exp0.size() != 0}, 1);
            if (exp0.size() != 0)
              check({tg[g], "_data"}, {24'd0, data[g]}, {24'd0, exp0.pop_front()});
          end else begin
            check({tg[g], "_sbq"}, {31'd0, exp1.size() != 0}, 1);
            if (exp1.size() != 0)
              check({tg[g], "_data"}, {24'd0, data[g]}, {24'd0, exp1.pop_front()});
          end
        end
        pv[g] = valid[g];
        pr[g] = m_ready;
        pd[g] = data[g];
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [7:0] d);
    we = 1'b1;
    wd = d;
    exp0.push_back(d);
    exp1.push_back(d);
    tick(1);
    we = 1'b0;
  endtask

  task automatic drained(input string tag);
    check({tag, "_q0"}, exp0.size(), 0);
    check({tag, "_q1"}, exp1.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int first [2];
    int last  [2];
    int rc    [2];
    int d0    [2];
    int n;

    tick(2);
    for (int g = 0; g < 2; g++) begin
      check({tg[g], "_rst_v"}, {31'd0, valid[g]}, 0);
      check({tg[g], "_rst_l"}, {30'd0, lvl[g]}, 0);
      check({tg[g], "_rst_re"}, {31'd0, re[g]}, 0);
      check({tg[g], "_rst_d"}, {24'd0, data[g]}, 0);
    end
    rst = 1'b0;
    fclr = 1'b0;
    tick(1);

    // Full-depth burst, consumer always ready.
    m_ready = 1'b1;
    for (int i = 0; i < 16; i++) put(8'ha1 + 8'(i));
    d0 = dcnt;
    first = '{-1, -1};
    last  = '{-1, -1};
    blk = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++)
        if (valid[g]) begin
          if (first[g] < 0) first[g] = k;
          last[g] = k;
        end
    end
    check("ah1_lat", first[0], 1);
    check("ah0_lat", first[1], 2);
    for (int g = 0; g < 2; g++) begin
      check({tg[g], "_span"}, last[g] - first[g], 15);
      check({tg[g], "_cnt16"}, dcnt[g] - d0[g], 16);
      check({tg[g], "_idle_v"}, {31'd0, valid[g]}, 0);
      check({tg[g], "_idle_re"}, {31'd0, re[g]}, 0);
    end
    drained("t1");
    tick(1);

    // Stalled consumer: only two prefetch reads.
    m_ready = 1'b0;
    blk = 1'b1;
    for (int i = 0; i < 4; i++) put(8'ha1 + 8'(i));
    blk = 1'b0;
    rc = '{0, 0};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) rc[g] += int'(re[g]);
    end
    for (int g = 0; g < 2; g++) begin
      check({tg[g], "_re2"}, rc[g], 2);
      check({tg[g], "_lvl2"}, {30'd0, lvl[g]}, 2);
      check({tg[g], "_head"}, {24'd0, data[g]}, 32'ha1);
    end
    tick(1);
    m_ready = 1'b1;
    tick(8);
    drained("t2");

    // Random backpressure with concurrent writes.
    n = 0;
    for (int c = 0; c < 4000; c++) begin
      if (n == 256 && exp0.size() == 0 && exp1.size() == 0) break;
      m_ready = 1'($urandom_range(0, 1));
      if (n < 256 && fcnt[0] < 16 && fcnt[1] < 16 &&
          $urandom_range(0, 1) == 1) begin
        we = 1'b1;
        wd = n[7:0];
        exp0.push_back(n[7:0]);
        exp1.push_back(n[7:0]);
        n++;
      end else begin
        we = 1'b0;
      end
      tick(1);
    end
    we = 1'b0;
    check("t3_nwr", n, 256);
    drained("t3");

    // Single word: empty rises in the same clock as the read.
    m_ready = 1'b1;
    tick(2);
    d0 = dcnt;
    put(8'h55);
    tick(6);
    for (int g = 0; g < 2; g++)
      check({tg[g], "_once"}, dcnt[g] - d0[g], 1);
    drained("t4");

    // Reset while the buffer is full.
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(8'ha1 + 8'(i));
    tick(6);
    for (int g = 0; g < 2; g++)
      check({tg[g], "_prelvl"}, {30'd0, lvl[g]}, 2);
    #2;
    rst = 1'b1;
    fclr = 1'b1;
    #1;
    for (int g = 0; g < 2; g++) begin
      check({tg[g], "_arst_v"}, {31'd0, valid[g]}, 0);
      check({tg[g], "_arst_l"}, {30'd0, lvl[g]}, 0);
    end
    exp0.delete();
    exp1.delete();
    tick(1);
    rst = 1'b0;
    fclr = 1'b0;
    m_ready = 1'b1;
    d0 = dcnt;
    put(8'h11);
    tick(6);
    for (int g = 0; g < 2; g++)
      check({tg[g], "_post"}, dcnt[g] - d0[g], 1);
    drained("t5");

    // Empty FIFO, ready consumer: nothing moves.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        check({tg[g], "_e_re"}, {31'd0, re[g]}, 0);
        check({tg[g], "_e_v"}, {31'd0, valid[g]}, 0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
